puf_eval_ctrl: RTL and testbench

- Sequences one arbiter-PUF delay chain of CHAL_W MUX2to1 stage pairs.
- Accepts a seed challenge and drives the per-stage select bits.
- Fires the launch edge into both delay paths, samples the arbiter latch and majority-votes repeated evaluations.
- Assembles a RESP_W-bit response for the AES key path, with a per-bit instability mask.

---
 rtl/puf_pkg.sv | 22 ++
 rtl/puf_chal_lfsr.sv | 41 ++++
 rtl/puf_eval_ctrl.sv | 218 +++++++++++++++++++++
 tb/tb_puf_eval_ctrl.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/puf_pkg.sv
// Shared constants for the arbiter-PUF evaluation controller: FSM state
// encodings, the challenge LFSR feedback taps and the lockup-free seed.
package puf_pkg;

  // FSM state encoding, kept as plain constants for legacy tool flows.
  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_LOAD      = 3'd1;
  localparam state_t ST_LAUNCH    = 3'd2;
  localparam state_t ST_SAMPLE    = 3'd3;
  localparam state_t ST_DISCHARGE = 3'd4;
  localparam state_t ST_VOTE      = 3'd5;
  localparam state_t ST_DONE      = 3'd6;

  // Right-shifting Galois feedback for x^64 + x^63 + x^61 + x^60 + 1.
  localparam logic [63:0] LFSR_TAPS_64 = 64'hD800_0000_0000_0000;

  // Substituted for an all-zero seed, which would lock the LFSR at zero.
  localparam logic [63:0] SEED_ALT = 64'h0000_0000_0000_0001;

endpackage

// File: rtl/puf_chal_lfsr.sv
// Challenge generator: W-bit right-shifting Galois LFSR. Load takes priority
// over step; the state is presented directly as the next challenge.
module puf_chal_lfsr #(
  parameter int          W    = 64,
  parameter logic [W-1:0] TAPS = W'(64'hD800_0000_0000_0000)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         step,
  input  logic [W-1:0] seed,
  output logic [W-1:0] state
);

  logic [W-1:0] lfsr_q;
  logic [W-1:0] lfsr_d;

  // Next LFSR value: reload from seed, advance one Galois step, or hold.
  always_comb begin
    lfsr_d = lfsr_q;
    if (load) begin
      lfsr_d = seed;
    end else if (step) begin
      lfsr_d = {1'b0, lfsr_q[W-1:1]} ^ ({W{lfsr_q[0]}} & TAPS);
    end else begin
      lfsr_d = lfsr_q;
    end
  end

  // LFSR state register, cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= '0;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign state = lfsr_q;

endmodule

// File: rtl/puf_eval_ctrl.sv
// Arbiter-PUF evaluation controller. Drives per-stage challenge bits from an
// LFSR, pulses the launch edge into the delay chain, samples the synchronized
// arbiter output and majority-votes VOTES evaluations per response bit.
module puf_eval_ctrl
  import puf_pkg::*;
#(
  parameter int CHAL_W = 64,
  parameter int RESP_W = 8,
  parameter int VOTES  = 3,
  parameter int SETTLE = 8
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              ReqValid,
  output logic              ReqReady,
  input  logic [CHAL_W-1:0] ChalIn,
  output logic [CHAL_W-1:0] PufChal,
  output logic              PufLaunch,
  input  logic              PufArb,
  output logic [RESP_W-1:0] Resp,
  output logic [RESP_W-1:0] RespUnstable,
  output logic              RespValid,
  input  logic              RespReady,
  output logic              Busy
);

  localparam int CNT_W = $clog2(VOTES + 1);
  localparam int SET_W = $clog2(SETTLE);
  localparam int BIT_W = (RESP_W > 1) ? $clog2(RESP_W) : 1;

  localparam logic [SET_W-1:0]  SET_LAST  = SET_W'(SETTLE - 1);
  localparam logic [CNT_W-1:0]  VOTE_LAST = CNT_W'(VOTES - 1);
  localparam logic [CNT_W-1:0]  VOTE_HALF = CNT_W'(VOTES / 2);
  localparam logic [CNT_W-1:0]  VOTE_ALL  = CNT_W'(VOTES);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(RESP_W - 1);
  localparam logic [CHAL_W-1:0] SEED_W    = CHAL_W'(SEED_ALT);
  localparam logic [CHAL_W-1:0] TAPS_W    = CHAL_W'(LFSR_TAPS_64);

  // Synchronizer for the asynchronous arbiter latch.
  logic arb_meta_q;
  logic arb_sync_q;

  // FSM and datapath state.
  state_t            state_q,  state_d;
  logic [SET_W-1:0]  settle_q, settle_d;
  logic [CNT_W-1:0]  vote_q,   vote_d;
  logic [CNT_W-1:0]  ones_q,   ones_d;
  logic [BIT_W-1:0]  bit_q,    bit_d;
  logic [CHAL_W-1:0] chal_q,   chal_d;
  logic [RESP_W-1:0] resp_q,   resp_d;
  logic [RESP_W-1:0] unst_q,   unst_d;

  // Registered status outputs, decoded from the next state.
  logic launch_q, launch_d;
  logic rvalid_q, rvalid_d;
  logic rready_q, rready_d;
  logic busy_q,   busy_d;

  // LFSR control.
  logic              lfsr_load_s;
  logic              lfsr_step_s;
  logic [CHAL_W-1:0] lfsr_seed_s;
  logic [CHAL_W-1:0] lfsr_state_s;

  assign lfsr_seed_s = (ChalIn == '0) ? SEED_W : ChalIn;

  puf_chal_lfsr #(
    .W    (CHAL_W),
    .TAPS (TAPS_W)
  ) u_lfsr (
    .clk   (Clk),
    .rst_n (Rst_n),
    .load  (lfsr_load_s),
    .step  (lfsr_step_s),
    .seed  (lfsr_seed_s),
    .state (lfsr_state_s)
  );

  // Two-flop synchronizer, clocked continuously regardless of FSM state.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      arb_meta_q <= 1'b0;
      arb_sync_q <= 1'b0;
    end else begin
      arb_meta_q <= PufArb;
      arb_sync_q <= arb_meta_q;
    end
  end

  // FSM next-state and datapath update for load/launch/sample/vote sequencing.
  always_comb begin
    state_d     = state_q;
    settle_d    = settle_q;
    vote_d      = vote_q;
    ones_d      = ones_q;
    bit_d       = bit_q;
    chal_d      = chal_q;
    resp_d      = resp_q;
    unst_d      = unst_q;
    lfsr_load_s = 1'b0;
    lfsr_step_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ReqValid && rready_q) begin
          lfsr_load_s = 1'b1;
          bit_d       = '0;
          vote_d      = '0;
          ones_d      = '0;
          settle_d    = '0;
          state_d     = ST_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        chal_d   = lfsr_state_s;
        settle_d = '0;
        state_d  = ST_LAUNCH;
      end
      ST_LAUNCH: begin
        if (settle_q == SET_LAST) begin
          settle_d = '0;
          state_d  = ST_SAMPLE;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      ST_SAMPLE: begin
        ones_d  = ones_q + CNT_W'(arb_sync_q);
        state_d = ST_DISCHARGE;
      end
      ST_DISCHARGE: begin
        if (settle_q == SET_LAST) begin
          settle_d = '0;
          if (vote_q < VOTE_LAST) begin
            vote_d  = vote_q + 1'b1;
            state_d = ST_LAUNCH;
          end else begin
            state_d = ST_VOTE;
          end
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      ST_VOTE: begin
        resp_d[bit_q] = (ones_q > VOTE_HALF);
        unst_d[bit_q] = (ones_q != '0) && (ones_q != VOTE_ALL);
        lfsr_step_s   = 1'b1;
        ones_d        = '0;
        vote_d        = '0;
        if (bit_q == BIT_LAST) begin
          state_d = ST_DONE;
        end else begin
          bit_d   = bit_q + 1'b1;
          state_d = ST_LOAD;
        end
      end
      ST_DONE: begin
        if (RespReady) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Status outputs follow the state being entered so they align with it.
  always_comb begin
    launch_d = (state_d == ST_LAUNCH) || (state_d == ST_SAMPLE);
    rvalid_d = (state_d == ST_DONE);
    rready_d = (state_d == ST_IDLE);
    busy_d   = (state_d != ST_IDLE);
  end

  // FSM, counters and output registers; reset drops launch immediately.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q  <= ST_IDLE;
      settle_q <= '0;
      vote_q   <= '0;
      ones_q   <= '0;
      bit_q    <= '0;
      chal_q   <= '0;
      resp_q   <= '0;
      unst_q   <= '0;
      launch_q <= 1'b0;
      rvalid_q <= 1'b0;
      rready_q <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      vote_q   <= vote_d;
      ones_q   <= ones_d;
      bit_q    <= bit_d;
      chal_q   <= chal_d;
      resp_q   <= resp_d;
      unst_q   <= unst_d;
      launch_q <= launch_d;
      rvalid_q <= rvalid_d;
      rready_q <= rready_d;
      busy_q   <= busy_d;
    end
  end

  assign PufChal      = chal_q;
  assign PufLaunch    = launch_q;
  assign Resp         = resp_q;
  assign RespUnstable = unst_q;
  assign RespValid    = rvalid_q;
  assign ReqReady     = rready_q;
  assign Busy         = busy_q;

endmodule

// File: tb/tb_puf_eval_ctrl.sv
// Directed bench for puf_eval_ctrl with a behavioural arbiter-chain model.
module tb_puf_eval_ctrl;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic        ReqValid = 1'b0;
  logic        ReqReady;
  logic [63:0] ChalIn = 64'h0;
  logic [63:0] PufChal;
  logic        PufLaunch;
  logic        PufArb;
  logic [7:0]  Resp;
  logic [7:0]  RespUnstable;
  logic        RespValid;
  logic        RespReady = 1'b0;
  logic        Busy;

  int total = 0;
  int bad   = 0;

  puf_eval_ctrl #(
    .CHAL_W (64),
    .RESP_W (8),
    .VOTES  (3),
    .SETTLE (4)
  ) dut (
    .Clk          (Clk),
    .Rst_n        (Rst_n),
    .ReqValid     (ReqValid),
    .ReqReady     (ReqReady),
    .ChalIn       (ChalIn),
    .PufChal      (PufChal),
    .PufLaunch    (PufLaunch),
    .PufArb       (PufArb),
    .Resp         (Resp),
    .RespUnstable (RespUnstable),
    .RespValid    (RespValid),
    .RespReady    (RespReady),
    .Busy         (Busy)
  );

  always #5 Clk = ~Clk;

  // Arbiter model: 0 = tied high, 1 = XOR of challenge, 2 = forced sequence.
  int          arb_mode    = 0;
  logic        arb_force   = 1'b0;
  logic [23:0] force_seq   = 24'h0;
  int          launch_cnt  = 0;
  int          launch_base = 0;
  int          cyc_now     = 0;

  assign PufArb = (arb_mode == 0) ? 1'b1 : (arb_mode == 1) ? ^PufChal : arb_force;

  // Count launch pulses and pick the forced arbiter value for each one.
  always @(posedge PufLaunch) begin
    if ((launch_cnt - launch_base) >= 0 && (launch_cnt - launch_base) < 24)
      arb_force = force_seq[launch_cnt - launch_base];
    else
      arb_force = 1'b0;
    launch_cnt = launch_cnt + 1;
  end

  // Free-running cycle counter for latency measurement.
  always @(posedge Clk) cyc_now = cyc_now + 1;

  // Challenge monitor: change count, zero detection, per-bit stability.
  logic        mon_en   = 1'b0;
  logic        mon_clr  = 1'b0;
  logic        chk_chal = 1'b0;
  logic [63:0] prev_chal = 64'h0;
  logic [63:0] exp_chal [8];
  int          chg_cnt  = 0;
  int          zero_cnt = 0;
  int          chal_bad = 0;
  int          chal_chk = 0;

  always @(negedge Clk) begin
    if (mon_clr) begin
      chg_cnt  = 0;
      zero_cnt = 0;
      chal_bad = 0;
      chal_chk = 0;
    end else if (mon_en) begin
      if (PufChal != prev_chal) chg_cnt = chg_cnt + 1;
      if (PufChal == 64'h0) zero_cnt = zero_cnt + 1;
      if (chk_chal && PufLaunch && (launch_cnt > launch_base) && (launch_cnt - launch_base <= 24)) begin
        chal_chk = chal_chk + 1;
        if (PufChal != exp_chal[(launch_cnt - launch_base - 1) / 3]) chal_bad = chal_bad + 1;
      end
    end
    prev_chal = PufChal;
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_step(input logic [63:0] s);
    logic [63:0] n;
    n = s >> 1;
    if (s[0]) n = n ^ 64'hD800_0000_0000_0000;
    return n;
  endfunction

  int acc_cyc = 0;

  task automatic start_req(input logic [63:0] c);
    @(negedge Clk);
    ChalIn   = c;
    ReqValid = 1'b1;
    @(posedge Clk);
    #1;
    acc_cyc  = cyc_now;
    ReqValid = 1'b0;
  endtask

  task automatic wait_resp();
    int n;
    n = 0;
    while (!RespValid && n < 2000) begin
      @(posedge Clk);
      #1;
      n++;
    end
    check_val("resp_valid_seen", {63'h0, RespValid}, 64'h1);
  endtask

  task automatic wait_launch();
    int n;
    n = 0;
    while (!PufLaunch && n < 100) begin
      @(posedge Clk);
      #1;
      n++;
    end
    check_val("launch_seen", {63'h0, PufLaunch}, 64'h1);
  endtask

  task automatic finish_resp();
    @(negedge Clk);
    RespReady = 1'b1;
    @(posedge Clk);
    #1;
    RespReady = 1'b0;
    check_val("done_ready", {63'h0, ReqReady}, 64'h1);
    check_val("done_valid", {63'h0, RespValid}, 64'h0);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "watchdog expired");
  end

  logic [63:0] s;
  logic [7:0]  exp_resp;
  logic [7:0]  r_snap;
  logic [7:0]  u_snap;
  int          hold_bad;
  int          l_snap;

  initial begin
    // Power-on reset.
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    Rst_n = 1'b1;
    #1;
    check_val("por_ready", {63'h0, ReqReady}, 64'h1);
    check_val("por_busy",  {63'h0, Busy},     64'h0);

    // Reset asserted mid-LAUNCH drops launch without a clock edge.
    arb_mode = 0;
    start_req(64'h0000_0000_0000_1234);
    wait_launch();
    @(negedge Clk);
    #2;
    check_val("launch_pre_rst", {63'h0, PufLaunch}, 64'h1);
    Rst_n = 1'b0;
    #1;
    check_val("launch_async_drop", {63'h0, PufLaunch}, 64'h0);
    @(negedge Clk);
    Rst_n = 1'b1;
    #1;
    check_val("rst_ready",   {63'h0, ReqReady},     64'h1);
    check_val("rst_launch",  {63'h0, PufLaunch},    64'h0);
    check_val("rst_chal",    PufChal,               64'h0);
    check_val("rst_resp",    {56'h0, Resp},         64'h0);
    check_val("rst_unst",    {56'h0, RespUnstable}, 64'h0);
    check_val("rst_valid",   {63'h0, RespValid},    64'h0);
    check_val("rst_busy",    {63'h0, Busy},         64'h0);

    // Chain model: arbiter output is the XOR of the challenge bits.
    arb_mode = 1;
    s = 64'hDEAD_BEEF_0123_4567;
    for (int b = 0; b < 8; b++) begin
      exp_chal[b] = s;
      exp_resp[b] = ^s;
      s = ref_step(s);
    end
    @(posedge Clk);
    #1;
    mon_clr = 1'b1;
    @(posedge Clk);
    #1;
    mon_clr     = 1'b0;
    mon_en      = 1'b1;
    chk_chal    = 1'b1;
    launch_base = launch_cnt;
    start_req(64'hDEAD_BEEF_0123_4567);
    wait_resp();
    chk_chal = 1'b0;
    check_val("chain_resp",      {56'h0, Resp},         {56'h0, exp_resp});
    check_val("chain_unst",      {56'h0, RespUnstable}, 64'h0);
    check_val("chain_chal_chg",  chg_cnt,               64'd8);
    check_val("chain_chal_chk",  chal_chk,              64'd120);
    check_val("chain_chal_bad",  chal_bad,              64'd0);
    finish_resp();

    // Arbiter tied high: all ones, all stable, exact latency.
    arb_mode = 0;
    start_req(64'h0000_0000_0000_00A5);
    wait_resp();
    check_val("ones_latency", cyc_now - acc_cyc,     64'd232);
    check_val("ones_resp",    {56'h0, Resp},         64'hFF);
    check_val("ones_unst",    {56'h0, RespUnstable}, 64'h00);
    check_val("ones_busy",    {63'h0, Busy},         64'h1);
    finish_resp();

    // Forced votes: bit0 = 1,1,0 and bit1 = 0,0,1, remaining bits all 0.
    arb_mode    = 2;
    force_seq   = 24'h000023;
    launch_base = launch_cnt;
    start_req(64'h0F0F_0000_1111_2222);
    wait_resp();
    check_val("force_resp_lo", {62'h0, Resp[1:0]},         64'h1);
    check_val("force_unst_lo", {62'h0, RespUnstable[1:0]}, 64'h3);
    check_val("force_resp",    {56'h0, Resp},              64'h01);
    check_val("force_unst",    {56'h0, RespUnstable},      64'h03);
    finish_resp();

    // Zero seed is replaced with the alternate seed; challenge never zero.
    arb_mode = 0;
    @(posedge Clk);
    #1;
    mon_clr = 1'b1;
    @(posedge Clk);
    #1;
    mon_clr = 1'b0;
    start_req(64'h0);
    wait_launch();
    check_val("zero_first_chal", PufChal, 64'h1);
    wait_resp();
    check_val("zero_never_zero", zero_cnt,      64'd0);
    check_val("zero_resp",       {56'h0, Resp}, 64'hFF);

    // Back-pressure: response held, new requests ignored while in DONE.
    r_snap   = Resp;
    u_snap   = RespUnstable;
    l_snap   = launch_cnt;
    hold_bad = 0;
    @(negedge Clk);
    ReqValid = 1'b1;
    ChalIn   = 64'hFFFF_0000_FFFF_0000;
    for (int i = 0; i < 20; i++) begin
      @(posedge Clk);
      #1;
      if (Resp != r_snap || RespUnstable != u_snap || !RespValid || ReqReady) hold_bad++;
    end
    check_val("hold_stable", hold_bad,                64'd0);
    check_val("hold_valid",  {63'h0, RespValid},      64'h1);
    check_val("hold_ready",  {63'h0, ReqReady},       64'h0);
    check_val("hold_nocap",  launch_cnt - l_snap,     64'd0);
    @(negedge Clk);
    ReqValid  = 1'b0;
    RespReady = 1'b1;
    @(posedge Clk);
    #1;
    RespReady = 1'b0;
    check_val("release_ready", {63'h0, ReqReady},  64'h1);
    check_val("release_valid", {63'h0, RespValid}, 64'h0);
    check_val("release_busy",  {63'h0, Busy},      64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
